// File: rtl/rotate_pkg.sv
// Shared defaults and width helpers for the unit-granular left rotator.
package rotate_pkg;

   localparam int unsigned UNITW = 8;
   localparam int unsigned GROUP = 4;

   // Offset field width for a word of g units; never narrower than one bit.
   function automatic int unsigned offset_width(input int unsigned g);
      return (g < 2) ? 1 : $clog2(g);
   endfunction

   typedef logic [$clog2(GROUP)-1:0] offset_t;

endpackage

// File: rtl/rotate_left_if.sv
// Input word/offset and registered result bundle for rotate_left.
interface rotate_left_if
   import rotate_pkg::*;
#(
   parameter int unsigned unitw = UNITW,
   parameter int unsigned group = GROUP
) ();

   localparam int unsigned WW = offset_width(group);

   logic                   in_valid;
   logic [WW-1:0]          in_w;
   logic [unitw*group-1:0] in_a;
   logic                   out_valid;
   logic [unitw*group-1:0] out_y;

   modport master (output in_valid, in_w, in_a, input out_valid, out_y);
   modport slave  (input in_valid, in_w, in_a, output out_valid, out_y);

endinterface

// File: rtl/rotate_left_stage.sv
// One barrel stage: rotates the word left by `shift` units when its offset bit is set.
// With ROTATE_LEFT_STAGED_EN defined the stage output is registered.
module rotate_left_stage
   import rotate_pkg::*;
#(
   parameter int unsigned unitw = UNITW,
   parameter int unsigned group = GROUP,
   parameter int unsigned shift = 1
) (
`ifdef ROTATE_LEFT_STAGED_EN
   input  logic                       clk,
   input  logic                       rst,
`endif
   input  logic                       in_valid,
   input  logic [$clog2(group)-1:0]   in_w,
   input  logic [unitw*group-1:0]     in_a,
   output logic                       out_valid,
   output logic [$clog2(group)-1:0]   out_w,
   output logic [unitw*group-1:0]     out_a
);

   localparam int unsigned N   = unitw * group;
   localparam int unsigned BIT = $clog2(shift);

   logic [N-1:0] rot;

   always_comb begin
      rot = in_a;
      if (in_w[BIT])
         rot = (in_a << (shift * unitw)) | (in_a >> ((group - shift) * unitw));
   end

`ifdef ROTATE_LEFT_STAGED_EN
   // Data and offset only advance with a valid word so an idle pipe keeps its last result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_w     <= '0;
         out_a     <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_w <= in_w;
            out_a <= rot;
         end
      end
   end
`else
   assign out_valid = in_valid;
   assign out_w     = in_w;
   assign out_a     = rot;
`endif

endmodule

// File: rtl/rotate_left.sv
// Unit-granular left rotator: out_y = in_a rotated toward the MSB by in_w units.
// Build option ROTATE_LEFT_STAGED_EN registers every barrel stage (latency WW instead of 1).
module rotate_left
   import rotate_pkg::*;
#(
   parameter int unsigned unitw = UNITW,
   parameter int unsigned group = GROUP
) (
   input  logic          clk,
   input  logic          rst,
   rotate_left_if.slave  bus
);

   localparam int unsigned N  = unitw * group;
   localparam int unsigned WW = offset_width(group);

   logic [N-1:0]  a_s [0:WW];
   logic [WW-1:0] w_s [0:WW];
   logic          v_s [0:WW];

   assign a_s[0] = bus.in_a;
   assign w_s[0] = bus.in_w;
   assign v_s[0] = bus.in_valid;

   for (genvar s = 0; s < WW; s++) begin : g_stage
      rotate_left_stage #(
         .unitw (unitw),
         .group (group),
         .shift (1 << s)
      ) u_stage (
`ifdef ROTATE_LEFT_STAGED_EN
         .clk       (clk),
         .rst       (rst),
`endif
         .in_valid  (v_s[s]),
         .in_w      (w_s[s]),
         .in_a      (a_s[s]),
         .out_valid (v_s[s+1]),
         .out_w     (w_s[s+1]),
         .out_a     (a_s[s+1])
      );
   end

`ifdef ROTATE_LEFT_STAGED_EN
   assign bus.out_valid = v_s[WW];
   assign bus.out_y     = a_s[WW];
`else
   logic         valid_q;
   logic [N-1:0] y_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         y_q     <= '0;
      end else begin
         valid_q <= v_s[WW];
         if (v_s[WW])
            y_q <= a_s[WW];
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_y     = y_q;
`endif

endmodule

// File: tb/tb_rotate_left.sv
// Directed and random checks of rotate_left at 8x4 and 4x8 unit geometries.
module tb_rotate_left;

`ifdef ROTATE_LEFT_STAGED_EN
   localparam int LAT1 = 2;
   localparam int LAT2 = 3;
`else
   localparam int LAT1 = 1;
   localparam int LAT2 = 1;
`endif
   localparam int NR = 1000;
   localparam logic [31:0] A = 32'h44332211;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   rotate_left_if #(.unitw(8), .group(4)) bus1 ();
   rotate_left_if #(.unitw(4), .group(8)) bus2 ();

   rotate_left #(.unitw(8), .group(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   rotate_left #(.unitw(4), .group(8)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply1(input logic [31:0] a, input logic [1:0] w);
      bus1.in_valid = 1'b1;
      bus1.in_w     = w;
      bus1.in_a     = a;
      step();
      bus1.in_valid = 1'b0;
      repeat (LAT1 - 1) step();
   endtask

   function automatic logic [31:0] ref_rot(input logic [31:0] a, input int unsigned w,
                                           input int unsigned uw, input int unsigned g);
      logic [63:0] d;
      d = {a, a};
      return 32'(d >> ((g - w) * uw));
   endfunction

   logic [31:0] exp1 [0:3] = '{32'h44332211, 32'h33221144, 32'h22114433, 32'h11443322};
   int          seq  [0:4] = '{0, 1, 2, 3, 0};

   bit          hv1 [0:NR+7];
   bit          hv2 [0:NR+7];
   logic [31:0] hy1 [0:NR+7];
   logic [31:0] hy2 [0:NR+7];

   initial begin
      logic [31:0] a, ey1, ey2;
      int unsigned w1, w2;
      int          idx;
      bit          ev;

      bus1.in_valid = 1'b0; bus1.in_w = '0; bus1.in_a = '0;
      bus2.in_valid = 1'b0; bus2.in_w = '0; bus2.in_a = '0;

      step();
      check("reset_valid", 32'(bus1.out_valid), 32'd0);
      check("reset_y", bus1.out_y, 32'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 4; i++) begin
         apply1(A, 2'(i));
         check($sformatf("rot_w%0d_y", i), bus1.out_y, exp1[i]);
         check($sformatf("rot_w%0d_valid", i), 32'(bus1.out_valid), 32'd1);
      end

      // Back-to-back: one result per clock, offset by the pipeline latency.
      for (int i = 0; i < 5 + LAT1 - 1; i++) begin
         if (i < 5) begin
            bus1.in_valid = 1'b1;
            bus1.in_w     = 2'(seq[i]);
            bus1.in_a     = A;
         end else begin
            bus1.in_valid = 1'b0;
         end
         step();
         if (i >= LAT1 - 1) begin
            check($sformatf("b2b_%0d_y", i - LAT1 + 1), bus1.out_y, exp1[seq[i - LAT1 + 1]]);
            check($sformatf("b2b_%0d_valid", i - LAT1 + 1), 32'(bus1.out_valid), 32'd1);
         end
      end
      bus1.in_valid = 1'b0;

      apply1(A, 2'd1);
      bus1.in_a = 32'hDEADBEEF;
      bus1.in_w = 2'd3;
      step();
      check("hold_valid", 32'(bus1.out_valid), 32'd0);
      check("hold_y", bus1.out_y, 32'h33221144);
      step();
      check("hold2_y", bus1.out_y, 32'h33221144);

      bus1.in_valid = 1'b1;
      bus1.in_w     = 2'd3;
      bus1.in_a     = A;
      step();
      bus1.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(bus1.out_valid), 32'd0);
      check("arst_y", bus1.out_y, 32'd0);
      step();
      rst = 1'b0;
      step();
      check("post_rst_idle_valid", 32'(bus1.out_valid), 32'd0);
      apply1(A, 2'd2);
      check("post_rst_y", bus1.out_y, 32'h22114433);
      check("post_rst_valid", 32'(bus1.out_valid), 32'd1);

      // Random regression on both geometries against the {A,A} shift formula.
      rst = 1'b1;
      step();
      rst = 1'b0;
      ey1 = '0;
      ey2 = '0;
      for (int c = 0; c < NR + 8; c++) begin
         if (c < NR) begin
            hv1[c] = ($urandom % 4) != 0;
            hv2[c] = ($urandom % 4) != 0;
            a  = $urandom;
            w1 = $urandom % 4;
            bus1.in_valid = hv1[c]; bus1.in_w = 2'(w1); bus1.in_a = a;
            hy1[c] = ref_rot(a, w1, 8, 4);
            a  = $urandom;
            w2 = $urandom % 8;
            bus2.in_valid = hv2[c]; bus2.in_w = 3'(w2); bus2.in_a = a;
            hy2[c] = ref_rot(a, w2, 4, 8);
         end else begin
            hv1[c] = 1'b0;
            hv2[c] = 1'b0;
            bus1.in_valid = 1'b0;
            bus2.in_valid = 1'b0;
         end
         step();

         idx = c - LAT1 + 1;
         ev  = (idx >= 0) ? hv1[idx] : 1'b0;
         if (ev) ey1 = hy1[idx];
         check("rnd1_valid", 32'(bus1.out_valid), 32'(ev));
         check("rnd1_y", bus1.out_y, ey1);

         idx = c - LAT2 + 1;
         ev  = (idx >= 0) ? hv2[idx] : 1'b0;
         if (ev) ey2 = hy2[idx];
         check("rnd2_valid", 32'(bus2.out_valid), 32'(ev));
         check("rnd2_y", bus2.out_y, ey2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
